// File: rtl/timer_seq_pkg.sv
// Shared constants for the interval-timer sequencer: timer register map,
// control-register bits and the sequencer state encoding.
package timer_seq_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;

    localparam logic [15:0] CTRL_ITO   = 16'h0001;
    localparam logic [15:0] CTRL_CONT  = 16'h0002;
    localparam logic [15:0] CTRL_START = 16'h0004;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    // One-shot start with interrupt enabled; halt with interrupt disabled.
    localparam logic [15:0] CTRL_GO   = (CTRL_START | CTRL_ITO) & ~CTRL_CONT;
    localparam logic [15:0] CTRL_HALT = CTRL_STOP & ~CTRL_ITO;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTL,
        S_WAIT,
        S_CLR_ST,
        S_STOP,
        S_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any_valid,
    output logic [IDX_W-1:0] idx
);

    int cand;

    // Scan from the farthest offset down so the nearest set request wins.
    always_comb begin
        any_valid = 1'b0;
        idx       = '0;
        cand      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (req[cand[IDX_W-1:0]]) begin
                any_valid = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Shares one interval timer among N_REQ one-shot delay requesters: arbitrates,
// programs the timer, waits for its irq, clears status and signals completion.
module timer_sequencer #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   delay,
    output logic [N_REQ-1:0]      done,
    output logic                  busy,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx,
    output logic [2:0]            tmr_address,
    output logic                  tmr_chipselect,
    output logic                  tmr_write_n,
    output logic [15:0]           tmr_writedata,
    input  logic                  tmr_irq
);

    import timer_seq_pkg::*;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic             cancelled;
    logic [15:0]      period_hi;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [31:0]      pick_delay;
    logic [IDX_W-1:0] ptr_next;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .any_valid (pick_valid),
        .idx       (pick_idx)
    );

    always_comb begin
        pick_delay = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_delay = delay[32*i +: 32];
            end
        end
    end

    assign ptr_next = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // The low half goes straight onto the bus at grant; only the high half
    // needs to survive until the second write.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && pick_valid) begin
            period_hi <= pick_delay[31:16];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            ptr            <= '0;
            cancelled      <= 1'b0;
            done           <= '0;
            busy           <= 1'b0;
            grant_valid    <= 1'b0;
            grant_idx      <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= ADDR_STATUS;
            tmr_writedata  <= '0;
        end else begin
            done           <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= ADDR_STATUS;
            tmr_writedata  <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_valid <= 1'b1;
                        grant_idx   <= pick_idx;
                        busy        <= 1'b1;
                        if (pick_delay == 32'd0) begin
                            state <= S_DONE;
                            done  <= onehot(pick_idx);
                        end else begin
                            state          <= S_WR_PL;
                            tmr_chipselect <= 1'b1;
                            tmr_write_n    <= 1'b0;
                            tmr_address    <= ADDR_PERIODL;
                            tmr_writedata  <= pick_delay[15:0];
                        end
                    end
                end
                S_WR_PL: begin
                    state          <= S_WR_PH;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= ADDR_PERIODH;
                    tmr_writedata  <= period_hi;
                end
                S_WR_PH: begin
                    state          <= S_WR_CTL;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= ADDR_CONTROL;
                    tmr_writedata  <= CTRL_GO;
                end
                S_WR_CTL: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A cancel wins over a coincident irq.
                    if (!req[grant_idx]) begin
                        state          <= S_STOP;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= ADDR_CONTROL;
                        tmr_writedata  <= CTRL_HALT;
                    end else if (tmr_irq) begin
                        state          <= S_CLR_ST;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= ADDR_STATUS;
                        tmr_writedata  <= '0;
                    end
                end
                S_STOP: begin
                    state          <= S_CLR_ST;
                    cancelled      <= 1'b1;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= ADDR_STATUS;
                    tmr_writedata  <= '0;
                end
                S_CLR_ST: begin
                    state <= S_DONE;
                    if (!cancelled) begin
                        done <= onehot(grant_idx);
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    grant_valid <= 1'b0;
                    busy        <= 1'b0;
                    ptr         <= ptr_next;
                    cancelled   <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: behavioural timer peripheral, bus/done/grant
// monitors and a round-robin scheduling model over randomized jobs.
module tb_timer_sequencer;

    localparam int N = 4;
    localparam int IDX_W = 2;
    localparam logic [31:0] STEP = 32'd1000;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        int          c;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [N-1:0]      req = '0;
    logic [32*N-1:0]   delay = '0;
    logic [N-1:0]      done;
    logic              busy;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [2:0]        tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [15:0]       tmr_writedata;
    logic              tmr_irq;
    logic              force_irq = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_ptr = 0;
    logic [31:0] dly [N];
    int exp_g[$];
    wr_t exp_w[$];

    timer_sequencer #(.N_REQ(N), .IDX_W(IDX_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .delay          (delay),
        .done           (done),
        .busy           (busy),
        .grant_valid    (grant_valid),
        .grant_idx      (grant_idx),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural interval timer: counts STEP ticks per clock, one-shot.
    logic [15:0] m_pl = '0, m_ph = '0;
    logic        m_ito = 1'b0, m_to = 1'b0, m_run = 1'b0;
    logic [31:0] m_cnt = '0;
    logic        m_irq;
    assign m_irq = m_to & m_ito;
    assign tmr_irq = m_irq | force_irq;

    always @(posedge clk) begin
        if (m_run) begin
            if (m_cnt <= STEP) begin
                m_to  <= 1'b1;
                m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - STEP;
            end
        end
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    m_ito <= tmr_writedata[0];
                    if (tmr_writedata[3]) m_run <= 1'b0;
                    else if (tmr_writedata[2]) begin
                        m_cnt <= {m_ph, m_pl};
                        m_run <= 1'b1;
                    end
                end
                3'd2: m_pl <= tmr_writedata;
                3'd3: m_ph <= tmr_writedata;
                default: ;
            endcase
        end
    end

    wr_t        wr_q[$];
    logic [N-1:0] dn_v[$];
    int         dn_c[$];
    int         gr_q[$];
    int         irq_first = -1;
    int         bus_err = 0;
    logic       gv_prev = 1'b0;

    always @(negedge clk) begin
        if (tmr_chipselect && !tmr_write_n) begin
            wr_q.push_back('{tmr_address, tmr_writedata, cyc});
            if (tmr_address == 3'd1 && tmr_writedata == 16'h0005) irq_first = -1;
        end else if (tmr_chipselect || !tmr_write_n || tmr_writedata != 16'h0) begin
            bus_err++;
        end
        if (irq_first < 0 && m_irq) irq_first = cyc;
        if (done != '0) begin
            dn_v.push_back(done);
            dn_c.push_back(cyc);
        end
        if (grant_valid && !gv_prev) gr_q.push_back(int'(grant_idx));
        gv_prev = grant_valid;
    end

    function automatic logic [32*N-1:0] pack_dly();
        logic [32*N-1:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = dly[i];
        return v;
    endfunction

    // Reference scheduling: each pending requester served in round-robin order.
    task automatic rr_model(input int left_in [N]);
        int left [N];
        int p;
        bit any;
        left = left_in;
        p = exp_ptr;
        exp_g.delete();
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (p + k) % N;
                if (!any && left[c] > 0) begin
                    any = 1'b1;
                    exp_g.push_back(c);
                    left[c]--;
                    p = (c + 1) % N;
                end
            end
        end
        exp_ptr = p;
    endtask

    task automatic model_job(input logic [31:0] d, input bit cancel);
        if (d != 32'd0) begin
            exp_w.push_back('{3'd2, d[15:0], 0});
            exp_w.push_back('{3'd3, d[31:16], 0});
            exp_w.push_back('{3'd1, 16'h0005, 0});
            if (cancel) exp_w.push_back('{3'd1, 16'h0008, 0});
            exp_w.push_back('{3'd0, 16'h0000, 0});
        end
    endtask

    // Requesters hold req until they have received their quota of done pulses.
    task automatic serve(input int left_in [N], input int bound, output bit to);
        int left [N];
        logic [N-1:0] m;
        int n;
        left = left_in;
        m = '0;
        for (int i = 0; i < N; i++) if (left[i] > 0) m[i] = 1'b1;
        delay = pack_dly();
        @(negedge clk);
        req = m;
        to = 1'b0;
        n = 0;
        while (m != '0 && !to) begin
            @(negedge clk);
            n++;
            if (n > bound) to = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (done[i] && left[i] > 0) begin
                    left[i]--;
                    if (left[i] == 0) m[i] = 1'b0;
                end
            end
            req = m;
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #3;
        n_checks++;
        if ({done, busy, grant_valid, grant_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %0h expected 0", {done, busy, grant_valid, grant_idx});
        end
        n_checks++;
        if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_bus: got %0h expected %0h",
                     {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_ptr = 0;
        @(negedge clk);
    endtask

    task automatic check_batch_round_robin(input string tag, input int left [N]);
        int gb, db, wb, eb;
        bit to;
        gb = gr_q.size(); db = dn_v.size(); wb = wr_q.size(); eb = bus_err;
        rr_model(left);
        exp_w.delete();
        foreach (exp_g[k]) model_job(dly[exp_g[k]], 1'b0);
        serve(left, 3000, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL %s_timeout: requests not served", tag); end
        n_checks++;
        if (gr_q.size() - gb != exp_g.size()) begin
            n_fail++; $display("FAIL %s_grant_count: got %0d expected %0d", tag, gr_q.size() - gb, exp_g.size());
        end
        for (int k = 0; k < exp_g.size(); k++) begin
            if (gb + k < gr_q.size()) begin
                n_checks++;
                if (gr_q[gb + k] != exp_g[k]) begin
                    n_fail++; $display("FAIL %s_grant%0d: got %0d expected %0d", tag, k, gr_q[gb + k], exp_g[k]);
                end
            end
            if (db + k < dn_v.size()) begin
                n_checks++;
                if (dn_v[db + k] !== (4'b0001 << exp_g[k])) begin
                    n_fail++; $display("FAIL %s_done%0d: got %b expected %b", tag, k, dn_v[db + k], 4'b0001 << exp_g[k]);
                end
            end
        end
        n_checks++;
        if (dn_v.size() - db != exp_g.size()) begin
            n_fail++; $display("FAIL %s_done_count: got %0d expected %0d", tag, dn_v.size() - db, exp_g.size());
        end
        n_checks++;
        if (wr_q.size() - wb != exp_w.size()) begin
            n_fail++; $display("FAIL %s_write_count: got %0d expected %0d", tag, wr_q.size() - wb, exp_w.size());
        end
        for (int k = 0; k < exp_w.size() && wb + k < wr_q.size(); k++) begin
            n_checks++;
            if ({wr_q[wb + k].a, wr_q[wb + k].d} !== {exp_w[k].a, exp_w[k].d}) begin
                n_fail++; $display("FAIL %s_write%0d: got (%0d,%h) expected (%0d,%h)", tag, k,
                                   wr_q[wb + k].a, wr_q[wb + k].d, exp_w[k].a, exp_w[k].d);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || bus_err != eb) begin
            n_fail++; $display("FAIL %s_idle: busy=%b bus_errors=%0d expected busy=0 errors=0", tag, busy, bus_err - eb);
        end
    endtask

    task automatic test_round_robin();
        int left [N];
        for (int i = 0; i < N; i++) dly[i] = 32'd10;
        left = '{2, 1, 1, 1};
        check_batch_round_robin("rr", left);
    endtask

    task automatic test_random();
        int left [N];
        logic [N-1:0] mask;
        for (int it = 0; it < 5; it++) begin
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                left[i] = mask[i] ? int'($urandom_range(1, 2)) : 0;
                dly[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 6000));
            end
            check_batch_round_robin($sformatf("rand%0d", it), left);
        end
    endtask

    task automatic test_single();
        int wb, db, t0, n;
        dly[0] = 32'h0001_86A0;
        delay = pack_dly();
        wb = wr_q.size(); db = dn_v.size();
        @(negedge clk);
        t0 = cyc;
        req = 4'b0001;
        n = 0;
        while (done == '0 && n < 400) begin @(negedge clk); n++; end
        req = '0;
        repeat (2) @(negedge clk);
        exp_w.delete();
        model_job(dly[0], 1'b0);
        n_checks++;
        if (wr_q.size() - wb != 4 || dn_v.size() - db != 1) begin
            n_fail++; $display("FAIL single_counts: writes=%0d dones=%0d expected 4 and 1", wr_q.size() - wb, dn_v.size() - db);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if ({wr_q[wb + k].a, wr_q[wb + k].d} !== {exp_w[k].a, exp_w[k].d}) begin
                    n_fail++; $display("FAIL single_write%0d: got (%0d,%h) expected (%0d,%h)", k,
                                       wr_q[wb + k].a, wr_q[wb + k].d, exp_w[k].a, exp_w[k].d);
                end
            end
            n_checks++;
            if (wr_q[wb].c != t0 + 1) begin
                n_fail++; $display("FAIL single_first_write: cycle %0d expected %0d", wr_q[wb].c, t0 + 1);
            end
            n_checks++;
            if (wr_q[wb + 3].c != irq_first + 1) begin
                n_fail++; $display("FAIL single_clear_cycle: cycle %0d expected %0d", wr_q[wb + 3].c, irq_first + 1);
            end
            n_checks++;
            if (dn_v[db] !== 4'b0001 || dn_c[db] != irq_first + 2) begin
                n_fail++; $display("FAIL single_done: got %b at %0d expected 0001 at %0d", dn_v[db], dn_c[db], irq_first + 2);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || gr_q[gr_q.size() - 1] != 0) begin
            n_fail++; $display("FAIL single_end: busy=%b grant=%0d expected busy=0 grant=0", busy, gr_q[gr_q.size() - 1]);
        end
        exp_ptr = 1;
    endtask

    task automatic test_zero_delay();
        int wb, db, t0, n;
        dly[2] = 32'd0;
        delay = pack_dly();
        wb = wr_q.size(); db = dn_v.size();
        @(negedge clk);
        t0 = cyc;
        req = 4'b0100;
        n = 0;
        while (done == '0 && n < 20) begin @(negedge clk); n++; end
        req = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dn_v.size() - db != 1 || dn_v[dn_v.size() - 1] !== 4'b0100 || dn_c[dn_c.size() - 1] != t0 + 1) begin
            n_fail++; $display("FAIL zero_done: count=%0d vec=%b cycle=%0d expected 1, 0100, %0d",
                               dn_v.size() - db, dn_v[dn_v.size() - 1], dn_c[dn_c.size() - 1], t0 + 1);
        end
        n_checks++;
        if (wr_q.size() != wb) begin
            n_fail++; $display("FAIL zero_writes: got %0d expected 0", wr_q.size() - wb);
        end
        exp_ptr = 3;
    endtask

    // Requester idx is granted a long job and cancelled; irq_too forces irq in the same cycle.
    task automatic cancel_job(input string tag, input int idx, input int wait_cyc, input bit irq_too);
        int wb, db, n, tdrop;
        dly[idx] = 32'h0010_0000;
        delay = pack_dly();
        wb = wr_q.size(); db = dn_v.size();
        @(negedge clk);
        req = 4'b0001 << idx;
        n = 0;
        while (!(tmr_chipselect && tmr_address == 3'd1) && n < 20) begin @(negedge clk); n++; end
        repeat (wait_cyc) @(negedge clk);
        tdrop = cyc;
        req = '0;
        if (irq_too) force_irq = 1'b1;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        exp_w.delete();
        model_job(dly[idx], 1'b1);
        n_checks++;
        if (wr_q.size() - wb != 5 || dn_v.size() != db) begin
            n_fail++; $display("FAIL %s_counts: writes=%0d dones=%0d expected 5 and 0", tag, wr_q.size() - wb, dn_v.size() - db);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if ({wr_q[wb + k].a, wr_q[wb + k].d} !== {exp_w[k].a, exp_w[k].d}) begin
                    n_fail++; $display("FAIL %s_write%0d: got (%0d,%h) expected (%0d,%h)", tag, k,
                                       wr_q[wb + k].a, wr_q[wb + k].d, exp_w[k].a, exp_w[k].d);
                end
            end
            n_checks++;
            if (wr_q[wb + 3].c != tdrop + 1) begin
                n_fail++; $display("FAIL %s_stop_cycle: cycle %0d expected %0d", tag, wr_q[wb + 3].c, tdrop + 1);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy=%b expected 0", tag, busy); end
        exp_ptr = (idx + 1) % N;
    endtask

    task automatic test_cancel();
        int left [N];
        cancel_job("cancel", 1, 5, 1'b0);
        for (int i = 0; i < N; i++) dly[i] = 32'd0;
        left = '{1, 0, 1, 0};
        check_batch_round_robin("after_cancel", left);
    endtask

    task automatic test_irq_cancel();
        int wb, db, n, tctl;
        cancel_job("irqcancel", 3, 3, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL stale_irq_idle: busy=%b grant_valid=%b expected 0 0", busy, grant_valid);
        end
        dly[0] = 32'd10;
        delay = pack_dly();
        wb = wr_q.size(); db = dn_v.size();
        req = 4'b0001;
        n = 0;
        while (!(tmr_chipselect && tmr_address == 3'd1) && n < 20) begin @(negedge clk); n++; end
        tctl = cyc;
        force_irq = 1'b0;
        n = 0;
        while (done == '0 && n < 50) begin @(negedge clk); n++; end
        req = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dn_v.size() - db != 1 || wr_q.size() - wb != 4) begin
            n_fail++; $display("FAIL stale_counts: dones=%0d writes=%0d expected 1 and 4", dn_v.size() - db, wr_q.size() - wb);
        end else begin
            n_checks++;
            if (dn_v[db] !== 4'b0001 || irq_first <= tctl || dn_c[db] != irq_first + 2) begin
                n_fail++; $display("FAIL stale_done: vec=%b cycle=%0d expected 0001 at %0d (ctl at %0d)",
                                   dn_v[db], dn_c[db], irq_first + 2, tctl);
            end
        end
        exp_ptr = 1;
    endtask

    task automatic test_reset_mid();
        int wb, db, n;
        dly[0] = 32'h0001_86A0;
        delay = pack_dly();
        @(negedge clk);
        req = 4'b0001;
        n = 0;
        while (!(tmr_chipselect && tmr_address == 3'd3) && n < 20) begin @(negedge clk); n++; end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({done, busy, grant_valid, grant_idx, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}
            !== {4'b0, 1'b0, 1'b0, 2'b0, 1'b0, 1'b1, 3'd0, 16'h0}) begin
            n_fail++; $display("FAIL midreset_outputs: got %h expected %h",
                {done, busy, grant_valid, grant_idx, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
                {4'b0, 1'b0, 1'b0, 2'b0, 1'b0, 1'b1, 3'd0, 16'h0});
        end
        repeat (2) @(negedge clk);
        wb = wr_q.size(); db = dn_v.size();
        reset_n = 1'b1;
        exp_ptr = 0;
        n = 0;
        while (done == '0 && n < 400) begin @(negedge clk); n++; end
        req = '0;
        repeat (2) @(negedge clk);
        exp_w.delete();
        model_job(dly[0], 1'b0);
        n_checks++;
        if (wr_q.size() - wb != 4 || dn_v.size() - db != 1) begin
            n_fail++; $display("FAIL midreset_counts: writes=%0d dones=%0d expected 4 and 1", wr_q.size() - wb, dn_v.size() - db);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if ({wr_q[wb + k].a, wr_q[wb + k].d} !== {exp_w[k].a, exp_w[k].d}) begin
                    n_fail++; $display("FAIL midreset_write%0d: got (%0d,%h) expected (%0d,%h)", k,
                                       wr_q[wb + k].a, wr_q[wb + k].d, exp_w[k].a, exp_w[k].d);
                end
            end
            n_checks++;
            if (dn_v[db] !== 4'b0001) begin n_fail++; $display("FAIL midreset_done: got %b expected 0001", dn_v[db]); end
        end
        exp_ptr = 1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) dly[i] = 32'd0;
        test_reset();
        test_round_robin();
        test_single();
        test_zero_delay();
        test_cancel();
        test_irq_cancel();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
